// File: rtl/chimp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chimp_pkg
//  Description : Shared types and helpers for the chimp memory game control
//                path: FSM state encoding, per-cell field offsets and a
//                ceiling-log2 helper for sizing cell indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package chimp_pkg;

   // Encoding is visible on oState (debug LEDs), so the values are fixed.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLEAR     = 3'd1,
      ST_PLACE     = 3'd2,
      ST_SHOW      = 3'd3,
      ST_PLAY      = 3'd4,
      ST_LEVEL_UP  = 3'd5,
      ST_FAIL      = 3'd6,
      ST_GAME_OVER = 3'd7
   } state_t;

   // Number field sits at the bottom of each cell.
   localparam int NUM_LSB = 0;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Cell layout is {active, showing, number[NUM_W-1:0]}.
   function automatic int active_bit(input int num_w);
      return num_w + 1;
   endfunction

   function automatic int show_bit(input int num_w);
      return num_w;
   endfunction

endpackage : chimp_pkg
`default_nettype wire

// File: rtl/chimp_game_fsm_cell_placer.sv
`default_nettype none
// ============================================================================
//  Module      : chimp_cell_placer
//  Description : Turns the free-running PRNG value into a candidate cell
//                index and decides whether a number may be placed there:
//                the index must fall inside the grid and the cell must be
//                currently inactive.
//  Revision    : 1.0 - initial release
// ============================================================================
module chimp_cell_placer #(
   parameter int CELLS = 9,
   parameter int IDX_W = 4
) (
   input  logic [7:0]       rand_i,
   input  logic [CELLS-1:0] occupied_i,
   output logic             place_ok_o,
   output logic [IDX_W-1:0] place_idx_o
);

   logic [IDX_W-1:0]          w_idx;
   logic [(1 << IDX_W)-1:0]   w_occ_pad;

   assign w_idx       = rand_i[IDX_W-1:0];
   assign place_idx_o = w_idx;

   // Pad occupancy up to the full index range; padding reads as occupied so
   // out-of-grid indices are rejected even if the range test were removed.
   always_comb begin
      w_occ_pad               = '1;
      w_occ_pad[CELLS-1:0]    = occupied_i;
   end

   // Accept only in-grid, empty cells; anything else retries next cycle.
   always_comb begin
      place_ok_o = (int'(w_idx) < CELLS) && !w_occ_pad[w_idx];
   end

   // High PRNG bits are intentionally ignored.
   generate
      if (IDX_W < 8) begin : g_unused_rand
         logic w_unused_rand;
         assign w_unused_rand = ^rand_i[7:IDX_W];
      end
   endgenerate

endmodule : chimp_cell_placer
`default_nettype wire

// File: rtl/chimp_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : chimp_game_fsm
//  Description : Control path for the chimp memory game on a GRID_W x GRID_H
//                board. Places numbers 1..level on random empty cells, hides
//                them after the first correct click, checks ascending click
//                order and tracks level, score and lives.
//  Revision    : 1.0 - initial release
// ============================================================================
module chimp_game_fsm
   import chimp_pkg::*;
#(
   parameter int GRID_W     = 3,
   parameter int GRID_H     = 3,
   parameter int NUM_W      = 5,
   parameter int START_NUMS = 3,
   parameter int MAX_NUMS   = 9,
   parameter int LIVES      = 3
) (
   input  logic                                clk,
   input  logic                                iReset,
   input  logic                                iEnable,
   input  logic                                iMenu,
   input  logic [7:0]                          iRandNum,
   input  logic                                iClickValid,
   input  logic [2:0]                          iBoxX,
   input  logic [2:0]                          iBoxY,
   output logic [GRID_W*GRID_H*(NUM_W+2)-1:0]  oBoard,
   output logic [NUM_W-1:0]                    oLevel,
   output logic [7:0]                          oScore,
   output logic [2:0]                          oLives,
   output logic                                oGameOver,
   output logic [2:0]                          oState
);

   localparam int CELLS     = GRID_W * GRID_H;
   localparam int CW        = NUM_W + 2;
   localparam int BOARD_W   = CELLS * CW;
   localparam int IDX_W_RAW = clog2(CELLS);
   localparam int IDX_W     = (IDX_W_RAW < 1) ? 1 : IDX_W_RAW;
   localparam int ACT_B     = active_bit(NUM_W);
   localparam int SHW_B     = show_bit(NUM_W);

   state_t               state_q;
   logic [BOARD_W-1:0]   board_q;
   logic [NUM_W-1:0]     level_q;
   logic [7:0]           score_q;
   logic [2:0]           lives_q;
   logic                 gameover_q;
   logic [NUM_W:0]       k_q;        // one extra bit: counts to level+1
   logic [NUM_W-1:0]     exp_q;

   logic [CELLS-1:0]     w_occ;
   logic                 w_place_ok;
   logic [IDX_W-1:0]     w_place_idx;
   logic                 w_click;
   int                   w_cidx;
   logic                 w_cact;
   logic [NUM_W-1:0]     w_cnum;

   // Active bit of every cell feeds the placer's occupancy check.
   generate
      for (genvar g = 0; g < CELLS; g++) begin : g_occ
         assign w_occ[g] = board_q[g*CW + ACT_B];
      end
   endgenerate

   chimp_cell_placer #(
      .CELLS (CELLS),
      .IDX_W (IDX_W)
   ) u_placer (
      .rand_i      (iRandNum),
      .occupied_i  (w_occ),
      .place_ok_o  (w_place_ok),
      .place_idx_o (w_place_idx)
   );

   // Decode a click into an in-grid cell index and read that cell's fields.
   always_comb begin
      w_click = iClickValid && (int'(iBoxX) < GRID_W) && (int'(iBoxY) < GRID_H);
      w_cidx  = 0;
      if (w_click) begin
         w_cidx = int'(iBoxY) * GRID_W + int'(iBoxX);
      end
      w_cact = board_q[w_cidx*CW + ACT_B];
      w_cnum = board_q[w_cidx*CW + NUM_LSB +: NUM_W];
   end

   // Game FSM: reset/menu/disable return everything to the idle state.
   always_ff @(posedge clk) begin
      if (iReset || iMenu || !iEnable) begin
         state_q    <= ST_IDLE;
         board_q    <= '0;
         level_q    <= NUM_W'(START_NUMS);
         score_q    <= 8'd0;
         lives_q    <= 3'(LIVES);
         gameover_q <= 1'b0;
         k_q        <= '0;
         exp_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_CLEAR;
            end
            ST_CLEAR: begin
               board_q <= '0;
               k_q     <= (NUM_W+1)'(1);
               state_q <= ST_PLACE;
            end
            ST_PLACE: begin
               if (w_place_ok) begin
                  board_q[int'(w_place_idx)*CW +: CW] <= {2'b11, k_q[NUM_W-1:0]};
                  k_q <= k_q + 1'b1;
                  // Last number just placed: reveal the board.
                  if (k_q == {1'b0, level_q}) begin
                     exp_q   <= NUM_W'(1);
                     state_q <= ST_SHOW;
                  end
               end
            end
            ST_SHOW: begin
               if (w_click) begin
                  if (w_cact && (w_cnum == NUM_W'(1))) begin
                     for (int c = 0; c < CELLS; c++) begin
                        board_q[c*CW + SHW_B] <= 1'b0;
                     end
                     board_q[w_cidx*CW + ACT_B] <= 1'b0;
                     exp_q   <= NUM_W'(2);
                     state_q <= (level_q == NUM_W'(1)) ? ST_LEVEL_UP : ST_PLAY;
                  end else begin
                     state_q <= ST_FAIL;
                  end
               end
            end
            ST_PLAY: begin
               if (w_click) begin
                  if (w_cact && (w_cnum == exp_q)) begin
                     board_q[w_cidx*CW + ACT_B] <= 1'b0;
                     exp_q <= exp_q + 1'b1;
                     if (exp_q == level_q) begin
                        state_q <= ST_LEVEL_UP;
                     end
                  end else begin
                     state_q <= ST_FAIL;
                  end
               end
            end
            ST_LEVEL_UP: begin
               if (score_q != 8'hFF) begin
                  score_q <= score_q + 8'd1;
               end
               if (level_q < NUM_W'(MAX_NUMS)) begin
                  level_q <= level_q + 1'b1;
               end
               state_q <= ST_CLEAR;
            end
            ST_FAIL: begin
               lives_q <= lives_q - 3'd1;
               if (lives_q == 3'd1) begin
                  board_q    <= '0;
                  gameover_q <= 1'b1;
                  state_q    <= ST_GAME_OVER;
               end else begin
                  state_q <= ST_CLEAR;
               end
            end
            ST_GAME_OVER: begin
               state_q <= ST_GAME_OVER;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign oBoard    = board_q;
   assign oLevel    = level_q;
   assign oScore    = score_q;
   assign oLives    = lives_q;
   assign oGameOver = gameover_q;
   assign oState    = state_q;

endmodule : chimp_game_fsm
`default_nettype wire

// File: tb/tb_chimp_game_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chimp_game_fsm
//  Description : Randomised self-checking bench for chimp_game_fsm with a
//                behavioural game model (per-cell arrays, plain integers).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chimp_game_fsm;

   localparam int GW    = 3;
   localparam int GH    = 3;
   localparam int NW    = 5;
   localparam int SN    = 3;
   localparam int MN    = 9;
   localparam int LV    = 3;
   localparam int CELLS = GW * GH;
   localparam int CW    = NW + 2;
   localparam int BW    = CELLS * CW;

   // Game phases as numbered on the debug LEDs.
   localparam int P_IDLE = 0, P_CLEAR = 1, P_PLACE = 2, P_SHOW = 3;
   localparam int P_PLAY = 4, P_LVUP = 5, P_FAIL = 6, P_OVER = 7;

   logic          clk = 1'b0;
   logic          iReset = 1'b1;
   logic          iEnable = 1'b0;
   logic          iMenu = 1'b0;
   logic [7:0]    iRandNum = 8'd0;
   logic          iClickValid = 1'b0;
   logic [2:0]    iBoxX = 3'd0;
   logic [2:0]    iBoxY = 3'd0;
   logic [BW-1:0] oBoard;
   logic [NW-1:0] oLevel;
   logic [7:0]    oScore;
   logic [2:0]    oLives;
   logic          oGameOver;
   logic [2:0]    oState;

   chimp_game_fsm #(
      .GRID_W(GW), .GRID_H(GH), .NUM_W(NW),
      .START_NUMS(SN), .MAX_NUMS(MN), .LIVES(LV)
   ) dut (
      .clk(clk), .iReset(iReset), .iEnable(iEnable), .iMenu(iMenu),
      .iRandNum(iRandNum), .iClickValid(iClickValid),
      .iBoxX(iBoxX), .iBoxY(iBoxY),
      .oBoard(oBoard), .oLevel(oLevel), .oScore(oScore), .oLives(oLives),
      .oGameOver(oGameOver), .oState(oState)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase, m_k, m_next, m_level, m_score, m_lives;
   bit m_over;
   int m_num [CELLS];
   bit m_act [CELLS];
   bit m_shw [CELLS];

   function automatic logic [BW-1:0] m_board();
      logic [BW-1:0] b;
      b = '0;
      for (int c = 0; c < CELLS; c++) begin
         b[c*CW + NW + 1] = m_act[c];
         b[c*CW + NW]     = m_shw[c];
         for (int j = 0; j < NW; j++) b[c*CW + j] = m_num[c][j];
      end
      return b;
   endfunction

   task automatic m_wipe();
      for (int c = 0; c < CELLS; c++) begin
         m_num[c] = 0; m_act[c] = 0; m_shw[c] = 0;
      end
   endtask

   task automatic m_step(input bit rst, input bit en, input bit menu, input int rnd,
                         input bit cv, input int bx, input int by);
      int  c;
      bit  hit;
      hit = cv && bx < GW && by < GH;
      c   = hit ? by * GW + bx : 0;
      if (rst || menu || !en) begin
         m_wipe();
         m_phase = P_IDLE; m_level = SN; m_score = 0; m_lives = LV; m_over = 0;
      end else begin
         case (m_phase)
            P_IDLE:  m_phase = P_CLEAR;
            P_CLEAR: begin m_wipe(); m_k = 1; m_phase = P_PLACE; end
            P_PLACE: begin
               c = rnd % 16;
               if (c < CELLS && !m_act[c]) begin
                  m_act[c] = 1; m_shw[c] = 1; m_num[c] = m_k;
                  if (m_k == m_level) begin m_phase = P_SHOW; m_next = 1; end
                  m_k++;
               end
            end
            P_SHOW, P_PLAY: begin
               if (hit) begin
                  if (m_act[c] && m_num[c] == m_next) begin
                     if (m_phase == P_SHOW)
                        for (int j = 0; j < CELLS; j++) m_shw[j] = 0;
                     m_act[c] = 0;
                     m_phase = (m_next == m_level) ? P_LVUP : P_PLAY;
                     m_next++;
                  end else begin
                     m_phase = P_FAIL;
                  end
               end
            end
            P_LVUP: begin
               m_score = (m_score < 255) ? m_score + 1 : 255;
               m_level = (m_level < MN) ? m_level + 1 : MN;
               m_phase = P_CLEAR;
            end
            P_FAIL: begin
               m_lives--;
               if (m_lives == 0) begin m_wipe(); m_over = 1; m_phase = P_OVER; end
               else m_phase = P_CLEAR;
            end
            default: m_phase = P_OVER;
         endcase
      end
   endtask

   // One clock: drive, clock, advance model, compare 1 time unit later.
   task automatic cycle(input bit rst, input bit en, input bit menu, input int rnd,
                        input bit cv, input int bx, input int by);
      iReset = rst; iEnable = en; iMenu = menu; iRandNum = 8'(rnd);
      iClickValid = cv; iBoxX = 3'(bx); iBoxY = 3'(by);
      @(posedge clk);
      m_step(rst, en, menu, rnd, cv, bx, by);
      #1;
      check("state",    64'(oState),    64'(m_phase));
      check("board",    64'(oBoard),    64'(m_board()));
      check("level",    64'(oLevel),    64'(m_level));
      check("score",    64'(oScore),    64'(m_score));
      check("lives",    64'(oLives),    64'(m_lives));
      check("gameover", 64'(oGameOver), 64'(m_over));
   endtask

   int seq [5] = '{0, 0, 0, 4, 8};
   int rnd, bx, by, r;
   bit cv, en, menu, rst;

   initial begin
      m_wipe();
      m_phase = P_IDLE; m_level = SN; m_score = 0; m_lives = LV; m_over = 0;
      m_k = 0; m_next = 0;
      cycle(1, 1, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0);
      // Directed opening: PRNG 0,4,8 lands 1,2,3 on the diagonal.
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, seq[i], 0, 0, 0);
      check("open_state", 64'(oState), 64'd3);
      check("open_c0",    64'(oBoard[0*CW +: CW]), 64'h61);
      check("open_c4",    64'(oBoard[4*CW +: CW]), 64'h62);
      check("open_c8",    64'(oBoard[8*CW +: CW]), 64'h63);
      check("open_lvl",   64'(oLevel), 64'd3);
      // Out-of-grid clicks in SHOW are ignored.
      cycle(0, 1, 0, 0, 1, 3, 0);
      cycle(0, 1, 0, 0, 1, 0, 5);
      // Diagonal clicks clear the level.
      cycle(0, 1, 0, 0, 1, 0, 0);
      check("hide", 64'(oBoard[4*CW + NW]), 64'd0);
      cycle(0, 1, 0, 0, 1, 1, 1);
      cycle(0, 1, 0, 0, 1, 2, 2);
      cycle(0, 1, 0, 0, 0, 0, 0);
      check("lvup_score", 64'(oScore), 64'd1);
      check("lvup_level", 64'(oLevel), 64'd4);
      check("lvup_state", 64'(oState), 64'd1);

      // Randomised play, steered toward correct clicks to reach deep levels.
      for (int n = 0; n < 9000; n++) begin
         r    = $urandom_range(0, 999);
         rst  = (r < 2);
         menu = (r >= 2 && r < 9);
         en   = !(r >= 9 && r < 13);
         rnd  = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 15) : $urandom_range(0, 255);
         cv = 0; bx = 0; by = 0;
         r = $urandom_range(0, 99);
         if ((m_phase == P_SHOW || m_phase == P_PLAY) && r < 80) begin
            cv = 1;
            bx = $urandom_range(0, GW - 1); by = $urandom_range(0, GH - 1);
            if (r < 70) begin
               for (int c = 0; c < CELLS; c++)
                  if (m_act[c] && m_num[c] == m_next) begin bx = c % GW; by = c / GW; end
            end else if (r < 75) begin
               bx = $urandom_range(3, 7); by = $urandom_range(0, 7);
            end
         end else if (r < 10) begin
            cv = 1; bx = $urandom_range(0, 7); by = $urandom_range(0, 7);
         end
         cycle(rst, en, menu, rnd, cv, bx, by);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_chimp_game_fsm
`default_nettype wire

// File: doc/chimp_game_fsm.md
Name: chimp_game_fsm

Overview:
Parametrised control path for the chimp memory game. It generalises the fixed 3x3 board to a GRID_W x GRID_H grid with configurable number width, level range and life count. It places numbers 1..N on random empty cells using the shared free-running PRNG, shows them, and hides them after the first correct click. It then checks that clicks arrive in ascending order and tracks level, score and lives. It sits between the PRNG and mouse-to-box mapper on the input side, and the VGA board renderer on the output side.

Parameters:
GRID_W, 3, board columns
GRID_H, 3, board rows
NUM_W, 5, number field width per cell
START_NUMS, 3, numbers placed on the first level
MAX_NUMS, 9, level cap; must be <= GRID_W*GRID_H and <= 2^NUM_W-1
LIVES, 3, failures allowed before game over

Ports:
clk  in  1  system clock
iReset  in  1  synchronous active-high reset
iEnable  in  1  high while chimp mode is selected (iGameMode==2'b10 decoded upstream)
iMenu  in  1  KEY0 press pulse; return to menu
iRandNum  in  8  free-running PRNG value, new value every cycle
iClickValid  in  1  one-cycle pulse, mouse click mapped to a box
iBoxX  in  3  clicked column
iBoxY  in  3  clicked row
oBoard  out  GRID_W*GRID_H*(NUM_W+2)  cell i=y*GRID_W+x at [i*CW +: CW], CW=NUM_W+2; MSB=active, MSB-1=showing, low NUM_W bits=number
oLevel  out  NUM_W  current count of numbers
oScore  out  8  levels cleared, saturates at 255
oLives  out  3  remaining lives
oGameOver  out  1  high in GAME_OVER
oState  out  3  FSM state, for debug LEDs

Behaviour:
- Reset (iReset=1 at clk edge) sets: all oBoard bits 0, oLevel=START_NUMS, oScore=0, oLives=LIVES, oGameOver=0, state IDLE. All outputs are registered.
- iReset has priority over iMenu, and iMenu has priority over clicks. iMenu or iEnable=0 in any state: next cycle the board clears, counters go to their reset values, and the state is IDLE.
- IDLE: when iEnable=1, go to CLEAR. This also applies on the cycle iEnable rises after iMenu.
- CLEAR: one cycle. Zero every cell, set place counter k=1, go to PLACE.
- PLACE: idx=iRandNum[IDX_W-1:0] with IDX_W=clog2(cells). If idx<cells and cell idx is inactive, write {1,1,k} to it and increment k. Otherwise retry next cycle. At most one placement per cycle. When k exceeds oLevel, go to SHOW and set expected=1.
- SHOW: numbers visible.
  - Click on the cell holding 1: clear all showing bits, deactivate that cell, set expected=2, go to PLAY. If oLevel==1, go to LEVEL_UP instead.
  - Click on any other active cell, or on an inactive in-grid cell: go to FAIL.
- PLAY:
  - Click on the active cell whose number equals expected: deactivate it and increment expected. If expected was oLevel, go to LEVEL_UP.
  - Click on an inactive cell or a wrong number: go to FAIL.
- Clicks with iBoxX>=GRID_W or iBoxY>=GRID_H are ignored in every state. Clicks outside SHOW and PLAY are ignored.
- Click effects are visible on oBoard one cycle after the iClickValid edge.
- LEVEL_UP: one cycle. oScore++ (saturating), oLevel++ (capped at MAX_NUMS; at the cap the level repeats), go to CLEAR.
- FAIL: one cycle. oLives--. If the result is 0, go to GAME_OVER; else go to CLEAR with oLevel unchanged.
- GAME_OVER: oGameOver=1, board cleared. Hold until iMenu, iReset or iEnable=0.
- State encoding: IDLE=0, CLEAR=1, PLACE=2, SHOW=3, PLAY=4, LEVEL_UP=5, FAIL=6, GAME_OVER=7.

Decomposition:
- chimp_pkg: state encodings; cell field offsets (ACTIVE_BIT, SHOW_BIT, NUM_LSB) as functions of NUM_W; a clog2 helper.
- One sub-module, chimp_cell_placer: owns the PRNG rejection test and the occupancy check. It exposes place_ok/place_idx to the FSM.

Test Plan:
1. Reset, iEnable=1, PRNG stub feeding 0,4,8 -> after 5 cycles cells 0,4,8 hold {1,1,1},{1,1,2},{1,1,3}; state SHOW; oLevel=3.
2. PRNG stub feeding 15,4,4,2 with an existing placement at 4 -> out-of-range 15 and occupied 4 are rejected; the next placement lands at 2; k advances only on accepts.
3. From case 1, click (0,0),(1,1),(2,2) -> showing bits clear after the first click; after the third click, oScore=1, oLevel=4, state CLEAR.
4. From case 1, click (1,1) first -> FAIL, oLives=2, board re-placed with 3 numbers. Three such fails -> oGameOver=1, oLives=0, board all zero.
5. Click (3,0) and (0,5) in PLAY -> no state or board change. iClickValid in PLACE -> ignored.
6. iMenu mid-PLAY with oScore=2 -> next cycle IDLE, board zero, oScore=0, oLevel=3. iMenu and iClickValid asserted together -> the menu wins.
